// File: rtl/port_prioritizer.sv
// rtl/port_prioritizer.sv - packs three original-port requests into three prioritized memory lanes
//
// Purpose:
//   Each cycle the valid requests on ports 1..3 are scanned in a rotating
//   priority order and packed contiguously into lanes 1..3. Lane 1 has the
//   highest priority inside the memory. Each lane carries the ID of the port
//   that drives it. A per-lane delay line returns that ID aligned with the
//   memory read data. The delay line returns INVALID for writes and idle lanes.
//   A saturating counter records cycles with same-address write conflicts.
//
// Configuration:
//   PORT_PRIO_ROTATE_EN  defined   : round-robin priority, rotation pointer register
//                        undefined : fixed order 1 > 2 > 3, no rotation register
//
// Ports (n = 1,2,3):
//   clk, rst_n               clock, asynchronous active-low reset
//   portn_valid_in/wen_in    request present / write enable on original port n
//   portn_addr_in/wdata_in   request address / write data on original port n
//   portn_valid_out/wen_out  lane n carries a request / lane n write enable
//   portn_addr_out/wdata_out lane n address / write data
//   portn_orig_id_out        original port driving lane n (0 = none)
//   portn_rsp_orig_id        original port owning lane n read data, READ_LATENCY later
//   conflict_cnt             saturating count of same-address write-conflict cycles
//
// ID encoding: 0 = invalid, 1/2/3 = original port 1/2/3.

module port_prioritizer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  port1_valid_in,
  input  logic                  port1_wen_in,
  input  logic [ADDR_WIDTH-1:0] port1_addr_in,
  input  logic [DATA_WIDTH-1:0] port1_wdata_in,
  input  logic                  port2_valid_in,
  input  logic                  port2_wen_in,
  input  logic [ADDR_WIDTH-1:0] port2_addr_in,
  input  logic [DATA_WIDTH-1:0] port2_wdata_in,
  input  logic                  port3_valid_in,
  input  logic                  port3_wen_in,
  input  logic [ADDR_WIDTH-1:0] port3_addr_in,
  input  logic [DATA_WIDTH-1:0] port3_wdata_in,

  output logic                  port1_valid_out,
  output logic                  port1_wen_out,
  output logic [ADDR_WIDTH-1:0] port1_addr_out,
  output logic [DATA_WIDTH-1:0] port1_wdata_out,
  output logic [1:0]            port1_orig_id_out,
  output logic [1:0]            port1_rsp_orig_id,
  output logic                  port2_valid_out,
  output logic                  port2_wen_out,
  output logic [ADDR_WIDTH-1:0] port2_addr_out,
  output logic [DATA_WIDTH-1:0] port2_wdata_out,
  output logic [1:0]            port2_orig_id_out,
  output logic [1:0]            port2_rsp_orig_id,
  output logic                  port3_valid_out,
  output logic                  port3_wen_out,
  output logic [ADDR_WIDTH-1:0] port3_addr_out,
  output logic [DATA_WIDTH-1:0] port3_wdata_out,
  output logic [1:0]            port3_orig_id_out,
  output logic [1:0]            port3_rsp_orig_id,

  output logic [15:0]           conflict_cnt
);

  localparam logic [1:0] ORIG_PORT_INVALID_ID = 2'd0;
  localparam logic [1:0] ORIG_PORT_1_ID       = 2'd1;
  localparam logic [1:0] ORIG_PORT_3_ID       = 2'd3;

  // Successor in the cyclic order 1 -> 2 -> 3 -> 1.
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == ORIG_PORT_3_ID) ? ORIG_PORT_1_ID : id + 2'd1;
  endfunction

  // Requests gathered into arrays; index 0 is original port 1.
  logic [2:0]                 req_v;
  logic [2:0]                 req_w;
  logic [2:0][ADDR_WIDTH-1:0] req_a;
  logic [2:0][DATA_WIDTH-1:0] req_d;

  assign req_v = {port3_valid_in, port2_valid_in, port1_valid_in};
  assign req_w = {port3_wen_in, port2_wen_in, port1_wen_in};
  assign req_a = {port3_addr_in, port2_addr_in, port1_addr_in};
  assign req_d = {port3_wdata_in, port2_wdata_in, port1_wdata_in};

  // Lane state; index 0 is lane 1.
  logic [2:0]                 lane_v_d, lane_v_q;
  logic [2:0]                 lane_w_d, lane_w_q;
  logic [2:0][ADDR_WIDTH-1:0] lane_a_d, lane_a_q;
  logic [2:0][DATA_WIDTH-1:0] lane_d_d, lane_d_q;
  logic [2:0][1:0]            lane_id_d, lane_id_q;

  logic [1:0] rr_ptr;

`ifdef PORT_PRIO_ROTATE_EN
  logic [1:0] rr_d, rr_q;
  logic       contention;

  assign contention = (req_v[0] & req_v[1]) | (req_v[0] & req_v[2]) | (req_v[1] & req_v[2]);

  // The port that just won lane 1 drops to the lowest priority under contention.
  always_comb begin
    rr_d = rr_q;
    if (contention) begin
      rr_d = next_id(lane_id_d[0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= ORIG_PORT_1_ID;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign rr_ptr = rr_q;
`else
  assign rr_ptr = ORIG_PORT_1_ID;
`endif

  // Scan ports starting at rr_ptr. Each valid one takes the next free lane,
  // so the occupied lanes are always contiguous from lane 1.
  always_comb begin
    logic [1:0] fill;
    logic [1:0] pid;
    logic [1:0] idx;
    lane_v_d  = '0;
    lane_w_d  = '0;
    lane_a_d  = '0;
    lane_d_d  = '0;
    lane_id_d = '0;
    fill      = 2'd0;
    pid       = rr_ptr;
    idx       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = pid - 2'd1;
      if (req_v[idx]) begin
        lane_v_d[fill]  = 1'b1;
        lane_w_d[fill]  = req_w[idx];
        lane_a_d[fill]  = req_a[idx];
        lane_d_d[fill]  = req_d[idx];
        lane_id_d[fill] = pid;
        fill            = fill + 2'd1;
      end
      pid = next_id(pid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_v_q  <= '0;
      lane_w_q  <= '0;
      lane_a_q  <= '0;
      lane_d_q  <= '0;
      lane_id_q <= '0;
    end else begin
      lane_v_q  <= lane_v_d;
      lane_w_q  <= lane_w_d;
      lane_a_q  <= lane_a_d;
      lane_d_q  <= lane_d_d;
      lane_id_q <= lane_id_d;
    end
  end

  // Conflict detection. Any matching pair flags the cycle, so a triple match counts once.
  logic [2:0]  req_wr;
  logic        conflict;
  logic [15:0] cnt_d, cnt_q;

  assign req_wr   = req_v & req_w;
  assign conflict = (req_wr[0] & req_wr[1] & (req_a[0] == req_a[1])) |
                    (req_wr[0] & req_wr[2] & (req_a[0] == req_a[2])) |
                    (req_wr[1] & req_wr[2] & (req_a[1] == req_a[2]));

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Response ID delay line. It is fed from the registered lane IDs, so the last stage
  // lines up with read data READ_LATENCY cycles after the lane outputs. Only reads
  // produce read data, so write and idle lanes enter as INVALID.
  logic [2:0][1:0] rsp_src;
  logic [2:0][1:0] dly_q [READ_LATENCY];

  always_comb begin
    rsp_src = '0;
    for (int l = 0; l < 3; l++) begin
      rsp_src[l] = (lane_v_q[l] && !lane_w_q[l]) ? lane_id_q[l] : ORIG_PORT_INVALID_ID;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= rsp_src;
      for (int i = 1; i < READ_LATENCY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign port1_valid_out   = lane_v_q[0];
  assign port1_wen_out     = lane_w_q[0];
  assign port1_addr_out    = lane_a_q[0];
  assign port1_wdata_out   = lane_d_q[0];
  assign port1_orig_id_out = lane_id_q[0];
  assign port1_rsp_orig_id = dly_q[READ_LATENCY-1][0];

  assign port2_valid_out   = lane_v_q[1];
  assign port2_wen_out     = lane_w_q[1];
  assign port2_addr_out    = lane_a_q[1];
  assign port2_wdata_out   = lane_d_q[1];
  assign port2_orig_id_out = lane_id_q[1];
  assign port2_rsp_orig_id = dly_q[READ_LATENCY-1][1];

  assign port3_valid_out   = lane_v_q[2];
  assign port3_wen_out     = lane_w_q[2];
  assign port3_addr_out    = lane_a_q[2];
  assign port3_wdata_out   = lane_d_q[2];
  assign port3_orig_id_out = lane_id_q[2];
  assign port3_rsp_orig_id = dly_q[READ_LATENCY-1][2];

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_port_prioritizer.sv
// tb/tb_port_prioritizer.sv - self-checking bench for port_prioritizer against a behavioural model

module tb_port_prioritizer;

  localparam int RL = 3;

  logic clk = 1'b0;
  logic rst_n;

  logic       in_v [1:3];
  logic       in_w [1:3];
  logic [7:0] in_a [1:3];
  logic [7:0] in_d [1:3];

  logic       out_v   [1:3];
  logic       out_w   [1:3];
  logic [7:0] out_a   [1:3];
  logic [7:0] out_d   [1:3];
  logic [1:0] out_id  [1:3];
  logic [1:0] out_rsp [1:3];
  logic [15:0] cnt;

  always #5 clk = ~clk;

  port_prioritizer #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .port1_valid_in(in_v[1]), .port1_wen_in(in_w[1]), .port1_addr_in(in_a[1]), .port1_wdata_in(in_d[1]),
    .port2_valid_in(in_v[2]), .port2_wen_in(in_w[2]), .port2_addr_in(in_a[2]), .port2_wdata_in(in_d[2]),
    .port3_valid_in(in_v[3]), .port3_wen_in(in_w[3]), .port3_addr_in(in_a[3]), .port3_wdata_in(in_d[3]),
    .port1_valid_out(out_v[1]), .port1_wen_out(out_w[1]), .port1_addr_out(out_a[1]),
    .port1_wdata_out(out_d[1]), .port1_orig_id_out(out_id[1]), .port1_rsp_orig_id(out_rsp[1]),
    .port2_valid_out(out_v[2]), .port2_wen_out(out_w[2]), .port2_addr_out(out_a[2]),
    .port2_wdata_out(out_d[2]), .port2_orig_id_out(out_id[2]), .port2_rsp_orig_id(out_rsp[2]),
    .port3_valid_out(out_v[3]), .port3_wen_out(out_w[3]), .port3_addr_out(out_a[3]),
    .port3_wdata_out(out_d[3]), .port3_orig_id_out(out_id[3]), .port3_rsp_orig_id(out_rsp[3]),
    .conflict_cnt(cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: expected lanes, response IDs, counter, rotation start.
  int         m_rr;
  logic       m_v   [1:3];
  logic       m_w   [1:3];
  logic [7:0] m_a   [1:3];
  logic [7:0] m_d   [1:3];
  logic [1:0] m_id  [1:3];
  logic [1:0] m_rsp [1:3];
  logic [15:0] m_cnt;
  logic [5:0] rspq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_lanes();
    for (int l = 1; l <= 3; l++) begin
      m_v[l] = 1'b0; m_w[l] = 1'b0; m_a[l] = 8'h00; m_d[l] = 8'h00; m_id[l] = 2'd0;
    end
  endtask

  task automatic model_reset();
    m_rr  = 1;
    m_cnt = 16'h0000;
    clear_lanes();
    for (int l = 1; l <= 3; l++) m_rsp[l] = 2'd0;
    rspq.delete();
    for (int i = 0; i < RL - 1; i++) rspq.push_back(6'd0);
  endtask

  task automatic model_edge();
    logic [5:0] sh;
    logic       hit;
    int         n;
    int         p;
    // read IDs currently on the lanes leave the model RL cycles later
    sh = 6'd0;
    for (int l = 1; l <= 3; l++)
      if (m_v[l] && !m_w[l]) sh[2*(l-1) +: 2] = m_id[l];
    rspq.push_back(sh);
    sh = rspq.pop_front();
    for (int l = 1; l <= 3; l++) m_rsp[l] = sh[2*(l-1) +: 2];
    hit = 1'b0;
    for (int i = 1; i <= 3; i++)
      for (int j = i + 1; j <= 3; j++)
        if (in_v[i] && in_w[i] && in_v[j] && in_w[j] && in_a[i] == in_a[j]) hit = 1'b1;
    if (hit && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    clear_lanes();
    n = 0;
    for (int k = 0; k < 3; k++) begin
      p = (m_rr - 1 + k) % 3 + 1;
      if (in_v[p]) begin
        n++;
        m_v[n] = 1'b1; m_w[n] = in_w[p]; m_a[n] = in_a[p]; m_d[n] = in_d[p]; m_id[n] = 2'(p);
      end
    end
`ifdef PORT_PRIO_ROTATE_EN
    if (n >= 2) m_rr = int'(m_id[1]) % 3 + 1;
`endif
  endtask

  task automatic check_all();
    for (int l = 1; l <= 3; l++) begin
      chk($sformatf("lane%0d", l), 32'({out_v[l], out_w[l], out_a[l], out_d[l], out_id[l]}),
          32'({m_v[l], m_w[l], m_a[l], m_d[l], m_id[l]}));
      chk($sformatf("rsp%0d", l), 32'(out_rsp[l]), 32'(m_rsp[l]));
    end
    chk("conflict_cnt", 32'(cnt), 32'(m_cnt));
  endtask

  task automatic set_port(input int p, input logic v, input logic w, input logic [7:0] a, input logic [7:0] d);
    in_v[p] = v; in_w[p] = w; in_a[p] = a; in_d[p] = d;
  endtask

  task automatic idle();
    for (int p = 1; p <= 3; p++) set_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic all_reads();
    set_port(1, 1'b1, 1'b0, 8'h10, 8'h01);
    set_port(2, 1'b1, 1'b0, 8'h20, 8'h02);
    set_port(3, 1'b1, 1'b0, 8'h30, 8'h03);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] seq [4];
`ifdef PORT_PRIO_ROTATE_EN
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd1;
`else
    seq[0] = 2'd1; seq[1] = 2'd1; seq[2] = 2'd1; seq[3] = 2'd1;
`endif

    // reset state
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // all three ports read
    all_reads();
    step();
    chk("rd_lane1", 32'({out_v[1], out_a[1], out_id[1]}), 32'({1'b1, 8'h10, 2'd1}));
    chk("rd_lane2", 32'({out_v[2], out_a[2], out_id[2]}), 32'({1'b1, 8'h20, 2'd2}));
    chk("rd_lane3", 32'({out_v[3], out_a[3], out_id[3]}), 32'({1'b1, 8'h30, 2'd3}));
    idle();
    repeat (RL) step();
    chk("rd_rsp", 32'({out_rsp[1], out_rsp[2], out_rsp[3]}), 32'({2'd1, 2'd2, 2'd3}));

    // rotation sequence from a fresh reset
    reset_pulse();
    all_reads();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rot_lane1_%0d", i), 32'(out_id[1]), 32'(seq[i]));
    end

    // single write on port 3
    idle();
    set_port(3, 1'b1, 1'b1, 8'h05, 8'hAB);
    step();
    chk("wr3_lane1", 32'({out_v[1], out_w[1], out_a[1], out_d[1], out_id[1]}),
        32'({1'b1, 1'b1, 8'h05, 8'hAB, 2'd3}));
    chk("wr3_lane23", 32'({out_v[2], out_id[2], out_v[3], out_id[3]}), 32'(0));
    idle();
    repeat (RL) step();
    chk("wr3_rsp1", 32'(out_rsp[1]), 32'(0));
    // single request left the rotation alone: next contention starts where it was
    all_reads();
    step();
`ifdef PORT_PRIO_ROTATE_EN
    chk("wr3_rr_held", 32'(out_id[1]), 32'(2));
`else
    chk("wr3_rr_held", 32'(out_id[1]), 32'(1));
`endif

    // three same-address write conflicts
    idle();
    set_port(1, 1'b1, 1'b1, 8'h44, 8'h11);
    set_port(2, 1'b1, 1'b1, 8'h44, 8'h22);
    repeat (3) step();
    chk("conflict_3", 32'(cnt), 32'(3));

    // randomized traffic on a narrow address range
    for (int i = 0; i < 400; i++) begin
      for (int p = 1; p <= 3; p++)
        set_port(p, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 3)), 8'($urandom));
      step();
    end

    // asynchronous reset with reads in flight
    all_reads();
    repeat (3) step();
    @(posedge clk);
    model_edge();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_lane1", 32'({out_v[1], out_id[1], out_rsp[1], out_rsp[2], out_rsp[3]}), 32'(0));
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < RL + 2; i++) begin
      step();
      chk($sformatf("arst_rsp_%0d", i), 32'({out_rsp[1], out_rsp[2], out_rsp[3]}), 32'(0));
    end
    all_reads();
    step();
    idle();
    repeat (RL) step();

    // counter saturation
    set_port(1, 1'b1, 1'b1, 8'h44, 8'h11);
    set_port(2, 1'b1, 1'b1, 8'h44, 8'h22);
    while (m_cnt != 16'hFFFE) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    check_all();
    chk("sat_fffe", 32'(cnt), 32'(16'hFFFE));
    step();
    chk("sat_ffff_a", 32'(cnt), 32'(16'hFFFF));
    step();
    chk("sat_ffff_b", 32'(cnt), 32'(16'hFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
